// File: rtl/lif_neuron_array.sv
// lif_neuron_array: leaky integrate-and-fire neurons, one captured input spike accumulated per cycle.
// Define LIF_REFRACTORY_EN to add a per-neuron refractory period of REF_STEPS timesteps.
module lif_neuron_array #(
    parameter int N_IN      = 784,
    parameter int N_OUT     = 10,
    parameter int W_WIDTH   = 8,
    parameter int V_WIDTH   = 16,
    parameter int REF_STEPS = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_IN-1:0]           spike_in,
    input  logic                      spike_valid,
    output logic                      spike_ready,
    input  logic                      clear,
    input  logic                      w_we,
    input  logic [$clog2(N_IN)-1:0]   w_addr_in,
    input  logic [$clog2(N_OUT)-1:0]  w_addr_out,
    input  logic signed [W_WIDTH-1:0] w_data,
    input  logic signed [V_WIDTH-1:0] threshold,
    input  logic [V_WIDTH-1:0]        leak,
    output logic [N_OUT-1:0]          out_spike,
    output logic                      out_valid
);
    localparam int IW = $clog2(N_IN);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

    state_t                    state;
    logic [IW-1:0]             i;
    logic [N_IN-1:0]           cap;
    logic signed [W_WIDTH-1:0] weight [N_OUT][N_IN];
    logic signed [V_WIDTH-1:0] v      [N_OUT];
    logic [V_WIDTH:0]          sum    [N_OUT];
    logic [V_WIDTH+1:0]        dl     [N_OUT];
    logic [V_WIDTH-1:0]        acc_v  [N_OUT];
    logic [V_WIDTH-1:0]        leak_v [N_OUT];
    logic [N_OUT-1:0]          fire;
    logic [N_OUT-1:0]          busy;
`ifdef LIF_REFRACTORY_EN
    localparam int RW = $clog2(REF_STEPS + 1);
    logic [RW-1:0]             ref_cnt [N_OUT];
`endif

    assign spike_ready = state == IDLE;

    // sum carries one guard bit so overflow shows as a sign disagreement and clamps instead of wrapping
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            sum[j]    = {v[j][V_WIDTH-1], v[j]} + {{(V_WIDTH + 1 - W_WIDTH){weight[j][i][W_WIDTH-1]}}, weight[j][i]};
            acc_v[j]  = sum[j][V_WIDTH] != sum[j][V_WIDTH-1] ? {sum[j][V_WIDTH], {(V_WIDTH - 1){~sum[j][V_WIDTH]}}} : sum[j][V_WIDTH-1:0];
            dl[j]     = {{2{v[j][V_WIDTH-1]}}, v[j]} - {2'b00, leak};
            leak_v[j] = dl[j][V_WIDTH+1] ? '0 : dl[j][V_WIDTH-1:0];
            fire[j]   = $signed(leak_v[j]) >= threshold;
`ifdef LIF_REFRACTORY_EN
            busy[j]   = ref_cnt[j] != '0;
`else
            busy[j]   = 1'b0;
`endif
        end
    end

    // weight storage has no reset so it can map onto RAM
    always_ff @(posedge clk)
        if (w_we && state == IDLE && 32'(w_addr_in) < N_IN && 32'(w_addr_out) < N_OUT)
            weight[w_addr_out][w_addr_in] <= w_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            cap       <= '0;
            out_valid <= 1'b0;
            out_spike <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v[j] <= '0;
`ifdef LIF_REFRACTORY_EN
                ref_cnt[j] <= '0;
`endif
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear)
                        for (int j = 0; j < N_OUT; j++) begin
                            v[j] <= '0;
`ifdef LIF_REFRACTORY_EN
                            ref_cnt[j] <= '0;
`endif
                        end
                    if (spike_valid) begin
                        cap   <= spike_in;
                        i     <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int j = 0; j < N_OUT; j++)
                        if (cap[i] && !busy[j]) v[j] <= acc_v[j];
                    i <= i + 1'b1;
                    if (i == I_LAST) state <= FIRE;
                end
                FIRE: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        out_spike[j] <= fire[j] && !busy[j];
                        if (!busy[j]) v[j] <= fire[j] ? '0 : leak_v[j];
`ifdef LIF_REFRACTORY_EN
                        ref_cnt[j] <= busy[j] ? ref_cnt[j] - 1'b1 : fire[j] ? RW'(REF_STEPS) : '0;
`endif
                    end
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
